// File: rtl/proc_isa_pkg.sv
// Shared ISA definitions: instruction field positions, ALU opcode values,
// rstatus exception codes and the multiply/divide sequencer state type.
package proc_isa_pkg;

    localparam int XLEN = 32;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 27;
    localparam int RD_MSB    = 26;
    localparam int RD_LSB    = 22;
    localparam int ALUOP_MSB = 6;
    localparam int ALUOP_LSB = 2;

    localparam logic [4:0] OPC_ALU   = 5'b00000;
    localparam logic [4:0] ALUOP_MUL = 5'b00110;
    localparam logic [4:0] ALUOP_DIV = 5'b00111;

    localparam logic [31:0] RSTATUS_MUL_OVF  = 32'd4;
    localparam logic [31:0] RSTATUS_DIV_ZERO = 32'd5;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_iter_core.sv
// Radix-2 datapath shared by multiply (shift-add) and divide (restoring).
// Operates on unsigned magnitudes; one iteration per i_step.
module md_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic                 i_is_div,
    input  logic [WIDTH-1:0]     i_load_lo,
    input  logic [WIDTH-1:0]     i_load_opnd,
    output logic [2*WIDTH-1:0]   o_acc_next
);

    // r_acc holds {partial product, multiplier} for mul, {remainder, quotient} for div
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_shrem;
    logic [WIDTH+1:0]   w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic               w_unused_bits;

    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + {1'b0, (r_acc[0] ? r_opnd : {WIDTH{1'b0}})};
        w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

        w_shrem    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_diff     = {1'b0, w_shrem} - {2'b00, r_opnd};
        // Remainder stays below the divisor, so only the low WIDTH bits survive
        w_div_next = w_diff[WIDTH+1]
                   ? {w_shrem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                   : {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

        o_acc_next = i_is_div ? w_div_next : w_mul_next;
    end

    assign w_unused_bits = ^{w_shrem[WIDTH], w_diff[WIDTH]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc  <= '0;
            r_opnd <= '0;
        end else if (i_load) begin
            r_acc  <= {{WIDTH{1'b0}}, i_load_lo};
            r_opnd <= i_load_opnd;
        end else if (i_step) begin
            r_acc  <= o_acc_next;
        end
    end

endmodule

// File: rtl/x_multdiv_unit.sv
// Execute-stage sequencer for iterative signed mul/div: stalls the front of
// the pipe while iterating and presents a one-cycle result to the X/M latch.
module x_multdiv_unit
    import proc_isa_pkg::*;
#(
    parameter int          WIDTH       = XLEN,
    parameter logic [4:0]  MUL_ALUOP   = ALUOP_MUL,
    parameter logic [4:0]  DIV_ALUOP   = ALUOP_DIV,
    parameter logic [31:0] RSTATUS_MUL = RSTATUS_MUL_OVF,
    parameter logic [31:0] RSTATUS_DIV = RSTATUS_DIV_ZERO
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [31:0]      ins_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             stall,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [4:0]       rd_out,
    output logic             exception,
    output logic [31:0]      rstatus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    md_state_t r_state;
    md_state_t w_state_next;

    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_neg;
    logic [4:0]       r_rd_cap;
    logic [WIDTH-1:0] r_result;
    logic             r_result_valid;
    logic [4:0]       r_rd_out;
    logic             r_exception;
    logic [31:0]      r_rstatus;

    logic             w_is_alu;
    logic             w_dec_mul;
    logic             w_dec_div;
    logic             w_dec_md;
    logic [4:0]       w_ins_rd;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_b_zero;
    logic             w_stall;
    logic             w_load;
    logic             w_step;
    logic             w_finish;
    logic             w_div0;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic               w_mul_ovf;
    logic               w_unused_ins;

    assign w_is_alu  = (ins_in[OPC_MSB:OPC_LSB] == OPC_ALU);
    assign w_dec_mul = w_is_alu && (ins_in[ALUOP_MSB:ALUOP_LSB] == MUL_ALUOP);
    assign w_dec_div = w_is_alu && (ins_in[ALUOP_MSB:ALUOP_LSB] == DIV_ALUOP);
    assign w_dec_md  = w_dec_mul || w_dec_div;
    assign w_ins_rd  = ins_in[RD_MSB:RD_LSB];
    assign w_a_mag   = a_in[WIDTH-1] ? ({WIDTH{1'b0}} - a_in) : a_in;
    assign w_b_mag   = b_in[WIDTH-1] ? ({WIDTH{1'b0}} - b_in) : b_in;
    assign w_b_zero  = (b_in == {WIDTH{1'b0}});
    assign w_unused_ins = ^{ins_in[RD_LSB-1:ALUOP_MSB+1], ins_in[ALUOP_LSB-1:0]};

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        w_div0       = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (w_dec_md) begin
                    w_stall = 1'b1;
                    w_load  = 1'b1;
                    if (w_dec_div && w_b_zero) begin
                        w_div0       = 1'b1;
                        w_state_next = MD_DONE;
                    end else begin
                        w_state_next = MD_BUSY;
                    end
                end
            end
            MD_BUSY: begin
                w_stall = 1'b1;
                w_step  = 1'b1;
                if (r_cnt == LAST_ITER) begin
                    w_finish     = 1'b1;
                    w_state_next = MD_DONE;
                end
            end
            // DONE lets D/X advance; the instruction still sitting there is not restarted
            MD_DONE: w_state_next = MD_IDLE;
            default: w_state_next = MD_IDLE;
        endcase
        // Flush aborts everything but stall, which stays a pure decode of state/ins_in
        if (flush) begin
            w_state_next = MD_IDLE;
            w_load       = 1'b0;
            w_step       = 1'b0;
            w_finish     = 1'b0;
            w_div0       = 1'b0;
        end
    end

    md_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_is_div    (r_is_div),
        .i_load_lo   (w_dec_div ? w_a_mag : w_b_mag),
        .i_load_opnd (w_dec_div ? w_b_mag : w_a_mag),
        .o_acc_next  (w_acc_next)
    );

    always_comb begin
        w_prod    = r_neg ? ({(2*WIDTH){1'b0}} - w_acc_next) : w_acc_next;
        w_quot    = r_neg ? ({WIDTH{1'b0}} - w_acc_next[WIDTH-1:0]) : w_acc_next[WIDTH-1:0];
        w_mul_ovf = !((&w_prod[2*WIDTH-1:WIDTH-1]) || !(|w_prod[2*WIDTH-1:WIDTH-1]));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt          <= '0;
            r_is_div       <= 1'b0;
            r_neg          <= 1'b0;
            r_rd_cap       <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_rd_out       <= '0;
            r_exception    <= 1'b0;
            r_rstatus      <= '0;
        end else begin
            r_result_valid <= 1'b0;
            if (flush || w_load) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_load) begin
                r_is_div <= w_dec_div;
                r_neg    <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                r_rd_cap <= w_ins_rd;
            end
            if (w_div0) begin
                r_result       <= '0;
                r_result_valid <= 1'b1;
                r_rd_out       <= w_ins_rd;
                r_exception    <= 1'b1;
                r_rstatus      <= RSTATUS_DIV;
            end else if (w_finish) begin
                r_result_valid <= 1'b1;
                r_rd_out       <= r_rd_cap;
                if (r_is_div) begin
                    r_result    <= w_quot;
                    r_exception <= 1'b0;
                    r_rstatus   <= '0;
                end else begin
                    r_result    <= w_prod[WIDTH-1:0];
                    r_exception <= w_mul_ovf;
                    r_rstatus   <= w_mul_ovf ? RSTATUS_MUL : 32'd0;
                end
            end
        end
    end

    assign stall        = w_stall;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign rd_out       = r_rd_out;
    assign exception    = r_exception;
    assign rstatus      = r_rstatus;

endmodule
